// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: wait, CKE, PRECHARGE ALL,
// N x AUTO REFRESH, LOAD MODE, then hold done until reinit or reset.
// Ports: sdram_clk, sdram_rst_ (async, active-low), reinit (DONE only),
// cke, cmd {cs_n,ras_n,cas_n,we_n}, addr, ba, init_busy, init_done.
module sdram_init_seq #(
   parameter int INIT_CNT = 16'h4000,
   parameter int CNT_W    = 16,
   parameter int CKE_LEAD = INIT_CNT >> 1,
   parameter int TRP      = 3,
   parameter int TRFC     = 8,
   parameter int TMRD     = 2,
   parameter int REF_NUM  = 8,
   parameter int ADDR_W   = 13,
   parameter logic [ADDR_W-1:0] MODE_REG = 'h033
) (
   input  logic              sdram_clk,
   input  logic              sdram_rst_,
   input  logic              reinit,
   output logic              cke,
   output logic [3:0]        cmd,
   output logic [ADDR_W-1:0] addr,
   output logic [1:0]        ba,
   output logic              init_busy,
   output logic              init_done
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   localparam int RW = $clog2(REF_NUM + 1);
   localparam int TW = 16;

   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(INIT_CNT - 1);
   localparam logic [CNT_W-1:0] LEAD    = CNT_W'(CKE_LEAD);
   localparam logic [RW-1:0]    REF_END = RW'(REF_NUM);

   // _W states hold T-1 cycles: load T-2 and count down to zero
   localparam logic [TW-1:0] TRP_LD  = TW'(TRP - 2);
   localparam logic [TW-1:0] TRFC_LD = TW'(TRFC - 2);
   localparam logic [TW-1:0] TMRD_LD = TW'(TMRD - 2);

   typedef enum logic [2:0] {
      S_WAIT,
      S_PRE,
      S_PRE_W,
      S_REF,
      S_REF_W,
      S_MRS,
      S_MRS_W,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [RW-1:0]    ref_cnt, ref_nxt;
   logic [TW-1:0]    tmr, tmr_nxt;
   logic             cke_on, cke_on_nxt;

   logic [RW-1:0]    ref_inc;
   logic             ref_hit;

   logic              cke_d;
   logic [3:0]        cmd_d;
   logic [ADDR_W-1:0] addr_d;
   logic [1:0]        ba_d;
   logic              busy_d;
   logic              done_d;

   assign ref_inc = ref_cnt + RW'(1);
   assign ref_hit = (ref_inc == REF_END);

   always_ff @(posedge sdram_clk or negedge sdram_rst_) begin
      if (!sdram_rst_) begin
         state   <= S_WAIT;
         cnt     <= '0;
         ref_cnt <= '0;
         tmr     <= '0;
         cke_on  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ref_cnt <= ref_nxt;
         tmr     <= tmr_nxt;
         cke_on  <= cke_on_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      ref_nxt    = ref_cnt;
      tmr_nxt    = tmr;
      cke_on_nxt = cke_on;
      unique case (state)
         S_WAIT: begin
            if (cnt == LEAD)
               cke_on_nxt = 1'b1;
            // counter parks at its final value on exit
            if (cnt == CNT_END)
               state_nxt = S_PRE;
            else
               cnt_nxt = cnt + CNT_W'(1);
         end
         S_PRE: begin
            ref_nxt = '0;
            tmr_nxt = TRP_LD;
            state_nxt = (TRP == 1) ? S_REF : S_PRE_W;
         end
         S_PRE_W: begin
            if (tmr == '0)
               state_nxt = S_REF;
            else
               tmr_nxt = tmr - TW'(1);
         end
         S_REF: begin
            tmr_nxt = TRFC_LD;
            if (TRFC == 1) begin
               ref_nxt = ref_inc;
               state_nxt = ref_hit ? S_MRS : S_REF;
            end else begin
               state_nxt = S_REF_W;
            end
         end
         S_REF_W: begin
            if (tmr == '0) begin
               ref_nxt = ref_inc;
               state_nxt = ref_hit ? S_MRS : S_REF;
            end else begin
               tmr_nxt = tmr - TW'(1);
            end
         end
         S_MRS: begin
            tmr_nxt = TMRD_LD;
            state_nxt = (TMRD == 1) ? S_DONE : S_MRS_W;
         end
         S_MRS_W: begin
            if (tmr == '0)
               state_nxt = S_DONE;
            else
               tmr_nxt = tmr - TW'(1);
         end
         S_DONE: begin
            if (reinit)
               state_nxt = S_PRE;
         end
         default: state_nxt = S_WAIT;
      endcase
   end

   always_comb begin
      cke_d  = cke_on;
      cmd_d  = CMD_NOP;
      addr_d = '0;
      ba_d   = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
      unique case (state)
         S_PRE: begin
            cmd_d = CMD_PRE;
            addr_d[10] = 1'b1;
         end
         S_REF: cmd_d = CMD_REF;
         S_MRS: begin
            cmd_d  = CMD_MRS;
            addr_d = MODE_REG;
         end
         S_DONE: begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sdram_clk or negedge sdram_rst_) begin
      if (!sdram_rst_) begin
         cke       <= 1'b0;
         cmd       <= CMD_NOP;
         addr      <= '0;
         ba        <= '0;
         init_busy <= 1'b1;
         init_done <= 1'b0;
      end else begin
         cke       <= cke_d;
         cmd       <= cmd_d;
         addr      <= addr_d;
         ba        <= ba_d;
         init_busy <= busy_d;
         init_done <= done_d;
      end
   end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: full schedule with INIT_CNT=16, a minimal
// timing variant, reinit in/out of DONE, and mid-refresh async reset.
module tb_sdram_init_seq;

   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] REF = 4'b0001;
   localparam logic [3:0] MRS = 4'b0000;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, rei_a, rei_b;
   logic        cke_a, cke_b;
   logic [3:0]  cmd_a, cmd_b;
   logic [12:0] addr_a, addr_b;
   logic [1:0]  ba_a, ba_b;
   logic        busy_a, busy_b, done_a, done_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sdram_init_seq #(
      .INIT_CNT(16),
      .CKE_LEAD(8)
   ) dut_a (
      .sdram_clk(clk),
      .sdram_rst_(rst_a),
      .reinit(rei_a),
      .cke(cke_a),
      .cmd(cmd_a),
      .addr(addr_a),
      .ba(ba_a),
      .init_busy(busy_a),
      .init_done(done_a)
   );

   sdram_init_seq #(
      .INIT_CNT(4),
      .CKE_LEAD(2),
      .TRP(1),
      .TRFC(1),
      .TMRD(1),
      .REF_NUM(1)
   ) dut_b (
      .sdram_clk(clk),
      .sdram_rst_(rst_b),
      .reinit(rei_b),
      .cke(cke_b),
      .cmd(cmd_b),
      .addr(addr_b),
      .ba(ba_b),
      .init_busy(busy_b),
      .init_done(done_b)
   );

   typedef struct {
      int          cyc;
      logic [3:0]  cmd;
      logic [12:0] addr;
   } ev_t;

   typedef struct {
      logic        rei;
      logic [3:0]  cmd;
      logic [12:0] addr;
      logic        cke;
      logic        busy;
      logic        done;
   } vec_t;

   ev_t  ev_a[$];
   vec_t vb[15];

   task automatic chk(input string nm, input int cyc,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] c,
                               input logic [12:0] a, input logic k,
                               input logic b, input logic d);
      vec_t v;
      v.rei = r; v.cmd = c; v.addr = a;
      v.cke = k; v.busy = b; v.done = d;
      return v;
   endfunction

   function automatic logic [16:0] exp_a(input int n);
      logic [16:0] r;
      r = {NOP, 13'h0};
      foreach (ev_a[i])
         if (ev_a[i].cyc == n)
            r = {ev_a[i].cmd, ev_a[i].addr};
      return r;
   endfunction

   task automatic chk_rst_a(input string tag);
      chk({tag, "_cke"}, -1, 32'(cke_a), 32'd0);
      chk({tag, "_cmd"}, -1, 32'(cmd_a), 32'(NOP));
      chk({tag, "_addr"}, -1, 32'(addr_a), 32'd0);
      chk({tag, "_ba"}, -1, 32'(ba_a), 32'd0);
      chk({tag, "_busy"}, -1, 32'(busy_a), 32'd1);
      chk({tag, "_done"}, -1, 32'(done_a), 32'd0);
   endtask

   // Cycle n = values just after the n-th edge following reset release.
   // reinit pulses after cycles 4 (WAIT) and 40 (refresh loop) must be
   // ignored; the one after cycle 104 lands in DONE.
   task automatic run_a(input int ncyc);
      logic [16:0] e;
      logic        d;
      for (int n = 0; n < ncyc; n++) begin
         @(posedge clk);
         #1;
         e = exp_a(n);
         d = (n >= 85 && n < 106) || n >= 175;
         chk("a_cmd", n, 32'(cmd_a), 32'(e[16:13]));
         chk("a_addr", n, 32'(addr_a), 32'(e[12:0]));
         chk("a_ba", n, 32'(ba_a), 32'd0);
         chk("a_cke", n, 32'(cke_a), 32'(n >= 9));
         chk("a_done", n, 32'(done_a), 32'(d));
         chk("a_busy", n, 32'(busy_a), 32'(!d));
         rei_a = (n == 4 || n == 40 || n == 104);
      end
      rei_a = 1'b0;
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      rei_a = 1'b0;
      rei_b = 1'b0;

      ev_a.push_back(ev_t'{16, PRE, 13'h400});
      for (int k = 0; k < 8; k++)
         ev_a.push_back(ev_t'{19 + 8 * k, REF, 13'h0});
      ev_a.push_back(ev_t'{83, MRS, 13'h033});
      ev_a.push_back(ev_t'{106, PRE, 13'h400});
      for (int k = 0; k < 8; k++)
         ev_a.push_back(ev_t'{109 + 8 * k, REF, 13'h0});
      ev_a.push_back(ev_t'{173, MRS, 13'h033});

      vb[0]  = mk(0, NOP, 13'h000, 0, 1, 0);
      vb[1]  = mk(1, NOP, 13'h000, 0, 1, 0);
      vb[2]  = mk(0, NOP, 13'h000, 0, 1, 0);
      vb[3]  = mk(0, NOP, 13'h000, 1, 1, 0);
      vb[4]  = mk(0, PRE, 13'h400, 1, 1, 0);
      vb[5]  = mk(1, REF, 13'h000, 1, 1, 0);
      vb[6]  = mk(0, MRS, 13'h033, 1, 1, 0);
      vb[7]  = mk(0, NOP, 13'h000, 1, 0, 1);
      vb[8]  = mk(1, NOP, 13'h000, 1, 0, 1);
      vb[9]  = mk(0, NOP, 13'h000, 1, 0, 1);
      vb[10] = mk(0, PRE, 13'h400, 1, 1, 0);
      vb[11] = mk(0, REF, 13'h000, 1, 1, 0);
      vb[12] = mk(0, MRS, 13'h033, 1, 1, 0);
      vb[13] = mk(0, NOP, 13'h000, 1, 0, 1);
      vb[14] = mk(0, NOP, 13'h000, 1, 0, 1);

      repeat (2) @(posedge clk);
      #1;
      chk_rst_a("a_rst");
      chk("b_rst_busy", -1, 32'(busy_b), 32'd1);
      chk("b_rst_cmd", -1, 32'(cmd_b), 32'(NOP));

      // power-up, done, ignored reinits, then reinit from DONE
      @(negedge clk);
      rst_a = 1'b1;
      run_a(180);

      // restart and reset asynchronously right after the 3rd REFRESH
      @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      run_a(36);
      #2;
      rst_a = 1'b0;
      #1;
      chk_rst_a("a_async");
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      run_a(90);

      // zero-gap timing variant, driven from the vector table
      @(negedge clk);
      rst_b = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         chk("b_cmd", i, 32'(cmd_b), 32'(vb[i].cmd));
         chk("b_addr", i, 32'(addr_b), 32'(vb[i].addr));
         chk("b_ba", i, 32'(ba_b), 32'd0);
         chk("b_cke", i, 32'(cke_b), 32'(vb[i].cke));
         chk("b_busy", i, 32'(busy_b), 32'(vb[i].busy));
         chk("b_done", i, 32'(done_b), 32'(vb[i].done));
         rei_b = vb[i].rei;
      end
      rei_b = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
- Parametrised SDRAM power-up initialisation sequencer that drives the command bus itself.
- Sequence: power-up wait, CKE ramp, PRECHARGE ALL, N × AUTO REFRESH, LOAD MODE REGISTER, then a sticky done flag.
- Sits between the SDRAM clock/reset domain and the sdramc command mux. The mux hands the bus to the main controller once init_done is high.
- Also supports a software-triggered re-initialisation (for example after a mode change) that skips the power-up wait.

Parameters:
- INIT_CNT, 16'h4000: power-up wait in sdram_clk cycles (≥100 us at target clock); must be ≥2.
- CNT_W, 16: wait-counter width; must hold INIT_CNT.
- CKE_LEAD, INIT_CNT>>1: wait-counter value at which cke rises; must be < INIT_CNT.
- TRP, 3: PRECHARGE-to-next-command spacing in cycles; must be ≥1.
- TRFC, 8: REFRESH-to-next-command spacing in cycles; must be ≥1.
- TMRD, 2: MRS-to-done spacing in cycles; must be ≥1.
- REF_NUM, 8: number of AUTO REFRESH commands; must be ≥1.
- ADDR_W, 13: SDRAM address width; must be ≥11.
- MODE_REG, 13'h033: value driven on addr during MRS, taken as the low ADDR_W bits.

Ports:
- sdram_clk  in  1  SDRAM clock.
- sdram_rst_  in  1  reset, asynchronous, active-low.
- reinit  in  1  one-cycle request to re-run the sequence from PRECHARGE; sampled only in DONE.
- cke  out  1  SDRAM clock enable.
- cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- addr  out  ADDR_W  SDRAM address bus.
- ba  out  2  bank address.
- init_busy  out  1  high while the sequence is running.
- init_done  out  1  high in DONE; the command mux selects the controller when set.

Behaviour:
- Interface: one clock, sdram_clk. Reset sdram_rst_ is asynchronous and active-low. All outputs are registered.
- Reset values: cke=0, cmd=NOP 4'b0111, addr=0, ba=0, init_busy=1, init_done=0. Wait counter=0, refresh counter=0, state=WAIT.
- Command encodings:
  - NOP 0111.
  - PRECHARGE 0010, with addr[10]=1 and ba=0.
  - AUTO REFRESH 0001.
  - LOAD MODE 0000, with addr=MODE_REG and ba=0.
  - In every non-command cycle cmd=NOP and addr=0.
- States: WAIT, PRE, PRE_W, REF, REF_W, MRS, MRS_W, DONE.
- WAIT:
  - The wait counter increments every cycle.
  - cke is set the cycle after the counter equals CKE_LEAD, and then stays 1 until reset.
  - When the counter equals INIT_CNT-1, go to PRE.
- Command states and their timing:
  - PRE, REF and MRS each last exactly one cycle and put the command on cmd in that cycle.
  - The following _W state holds NOP for T-1 cycles, where T is TRP, TRFC or TMRD respectively.
  - If T=1, the _W state is skipped.
  - The next command therefore appears exactly T cycles after the previous one.
- Refresh loop:
  - REF_W exit increments the refresh counter.
  - If the count has reached REF_NUM, go to MRS; otherwise go back to REF.
  - The counter is cleared on entry to PRE.
- DONE:
  - init_done=1 and init_busy=0, registered together on DONE entry.
  - cmd=NOP; the controller owns the bus.
  - reinit=1 in DONE: the next cycle is PRE, init_done falls and init_busy rises in that same cycle, and cke stays 1.
  - reinit outside DONE is ignored; no queuing.
- Latency:
  - First PRECHARGE is on cmd at the cycle INIT_CNT after the first clock edge with reset released; count that edge as cycle 0.
  - init_done rises exactly TRP + REF_NUM*TRFC + TMRD cycles after the first PRECHARGE cycle.
  - For reinit, the PRECHARGE appears 1 cycle after reinit is sampled.
- Reset mid-sequence: immediate asynchronous return to reset values, with cke dropping to 0. The full sequence, including the power-up wait, restarts on release.
- The wait counter saturates in WAIT exit and never wraps. It is not used after the first pass.

Test Plan:
- Power-up, INIT_CNT=16, CKE_LEAD=8, defaults otherwise, 1 cycle = 1 edge:
  - cke rises at cycle 9.
  - PRECHARGE at cycle 16 with addr[10]=1.
  - REFRESH at cycles 19, 27, …, 75 (8 commands).
  - MRS at 83 with addr=13'h033.
  - init_done rises at 85; init_busy falls at 85.
- TRP=TRFC=TMRD=1, REF_NUM=1, INIT_CNT=4: PRE at 4, REF at 5, MRS at 6, done at 7, with no NOP gaps.
- reinit pulse at 20 cycles after done:
  - PRECHARGE on the next cycle, init_done=0 and init_busy=1 at the same edge.
  - cke stays 1 throughout.
  - done returns TRP + REF_NUM*TRFC + TMRD cycles after that PRECHARGE.
- reinit asserted during the refresh loop and during WAIT: no change to the command schedule or timing.
- Reset asserted mid-refresh (3rd REFRESH):
  - All outputs return to reset values asynchronously, before the next edge; cke=0.
  - After release, the full schedule from scenario 1 repeats exactly.
- Over the entire run, cmd is only ever NOP, PRECHARGE, AUTO REFRESH or LOAD MODE, and every non-command cycle has addr=0.
